// File: rtl/ascii_dec_parser_if.sv
// Character-in / number-out handshake bundle for ascii_dec_parser.
// master = character source and result consumer, slave = the parser.
interface ascii_dec_parser_if #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) ();
  logic                            in_valid;
  logic                            in_ready;
  logic [7:0]                      in_char;
  logic                            out_valid;
  logic                            out_ready;
  logic [WIDTH-1:0]                out_value;
  logic [$clog2(MAX_DIGITS+1)-1:0] out_digits;
  logic                            out_ovf;
  logic                            out_err;

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_value, out_digits, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_value, out_digits, out_ovf, out_err
  );
endinterface

// File: rtl/ascii_dec_parser.sv
// Streaming ASCII decimal to binary converter, one character per beat, one result per number.
// Define ASCII2BIN_SIGN_EN to accept a leading '-' and produce two's complement results.
module ascii_dec_parser #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  ascii_dec_parser_if.slave bus,
  output logic              busy
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int AW = WIDTH + 4;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [AW-1:0] TEN     = AW'(10);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             ovf_reg;
  logic             err_reg;

  logic             is_digit;
  logic [3:0]       digit;
  logic [AW-1:0]    prod;
  logic [AW-1:0]    limit;
  logic             over;
  logic [WIDTH-1:0] acc_sat;
  logic [WIDTH-1:0] fin_value;
  logic             fin_err;

`ifdef ASCII2BIN_SIGN_EN
  localparam logic [AW-1:0] HALF = AW'(1) << (WIDTH - 1);
  logic neg_reg;
`endif

  assign bus.in_ready = (state_reg != DONE);
  assign busy         = (state_reg != IDLE);

  always_comb begin
    is_digit = (bus.in_char >= 8'h30) && (bus.in_char <= 8'h39);
    digit    = bus.in_char[3:0];
    prod     = ({4'b0000, acc_reg} * TEN) + {{(AW-4){1'b0}}, digit};
`ifdef ASCII2BIN_SIGN_EN
    // Magnitude is accumulated; the negative side may reach one further than the positive.
    limit     = neg_reg ? HALF : (HALF - AW'(1));
    fin_value = neg_reg ? (~acc_reg + WIDTH'(1)) : acc_reg;
    fin_err   = err_reg | (cnt_reg == '0);
`else
    limit     = {4'b0000, {WIDTH{1'b1}}};
    fin_value = acc_reg;
    fin_err   = err_reg;
`endif
    over    = (prod > limit);
    acc_sat = over ? limit[WIDTH-1:0] : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      ovf_reg        <= 1'b0;
      err_reg        <= 1'b0;
`ifdef ASCII2BIN_SIGN_EN
      neg_reg        <= 1'b0;
`endif
      bus.out_valid  <= 1'b0;
      bus.out_value  <= '0;
      bus.out_digits <= '0;
      bus.out_ovf    <= 1'b0;
      bus.out_err    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // acc_reg is zero here, so acc_sat is just the first digit
          if (bus.in_valid) begin
            if (is_digit) begin
              acc_reg   <= acc_sat;
              cnt_reg   <= CW'(1);
              ovf_reg   <= over;
              state_reg <= ACCUM;
            end
`ifdef ASCII2BIN_SIGN_EN
            else if (bus.in_char == 8'h2D) begin
              neg_reg   <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= ACCUM;
            end
`endif
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            if (is_digit) begin
              if (cnt_reg < MAX_CNT) begin
                acc_reg <= acc_sat;
                cnt_reg <= cnt_reg + CW'(1);
                ovf_reg <= ovf_reg | over;
              end else begin
                err_reg <= 1'b1;
              end
            end else begin
              state_reg      <= DONE;
              bus.out_valid  <= 1'b1;
              bus.out_value  <= fin_value;
              bus.out_digits <= cnt_reg;
              bus.out_ovf    <= ovf_reg;
              bus.out_err    <= fin_err;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            ovf_reg        <= 1'b0;
            err_reg        <= 1'b0;
`ifdef ASCII2BIN_SIGN_EN
            neg_reg        <= 1'b0;
`endif
            bus.out_valid  <= 1'b0;
            bus.out_value  <= '0;
            bus.out_digits <= '0;
            bus.out_ovf    <= 1'b0;
            bus.out_err    <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascii_dec_parser.sv
// Bench for ascii_dec_parser: fixed string table, hand-written handshake/reset sequences,
// then random character streams checked against a string-level number model.
module tb_ascii_dec_parser;
  localparam int WIDTH = 16;
  localparam int MAXD  = 5;
  localparam longint UMAX = (64'sd1 <<< WIDTH) - 1;
  localparam longint SMAX = (64'sd1 <<< (WIDTH - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  ascii_dec_parser_if #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) bus ();

  ascii_dec_parser #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct packed {
    logic [15:0] v;
    logic [2:0]  d;
    logic        o;
    logic        e;
  } res_t;

  typedef struct {
    string s;
    res_t  r;
  } vec_t;

  vec_t   tbl[$];
  res_t   exp_q[$];
  int     n_vec = 0;
  int     n_bad = 0;
  bit     use_model = 1'b1;
  bit     rand_rdy  = 1'b0;

  bit     m_in  = 1'b0;
  bit     m_neg = 1'b0;
  longint m_mag = 0;
  int     m_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Result of the number currently held by the model, from its digit string value.
  function automatic res_t model_result();
    res_t   r;
    longint val;
    bit     ovf;
`ifdef ASCII2BIN_SIGN_EN
    if (m_neg) begin
      ovf = (m_mag > SMAX + 1);
      val = ovf ? -(SMAX + 1) : -m_mag;
    end else begin
      ovf = (m_mag > SMAX);
      val = ovf ? SMAX : m_mag;
    end
    r.e = (m_cnt == 0) || (m_cnt > MAXD);
`else
    ovf = (m_mag > UMAX);
    val = ovf ? UMAX : m_mag;
    r.e = (m_cnt > MAXD);
`endif
    r.v = val[15:0];
    r.d = 3'((m_cnt > MAXD) ? MAXD : m_cnt);
    r.o = ovf;
    return r;
  endfunction

  function automatic void model_char(logic [7:0] c);
    bit dig;
    dig = (c >= 8'h30) && (c <= 8'h39);
    if (!m_in) begin
      if (dig) begin
        m_in = 1'b1; m_neg = 1'b0; m_cnt = 1; m_mag = longint'(c - 8'h30);
      end
`ifdef ASCII2BIN_SIGN_EN
      else if (c == 8'h2D) begin
        m_in = 1'b1; m_neg = 1'b1; m_cnt = 0; m_mag = 0;
      end
`endif
    end else if (dig) begin
      if (m_cnt < MAXD) m_mag = m_mag * 10 + longint'(c - 8'h30);
      m_cnt++;
    end else begin
      if (use_model) exp_q.push_back(model_result());
      m_in = 1'b0;
    end
  endfunction

  // Called at a falling edge; returns at the falling edge after the beat.
  task automatic send(logic [7:0] c);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else begin
      model_char(c);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic add(string s, logic [15:0] v, logic [2:0] d, logic o, logic e);
    vec_t t;
    t.s = s; t.r.v = v; t.r.d = d; t.r.o = o; t.r.e = e;
    tbl.push_back(t);
  endtask

  always @(negedge clk) begin
    res_t got;
    res_t want;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got = {bus.out_value, bus.out_digits, bus.out_ovf, bus.out_err};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h expected none", got);
      end else begin
        want = exp_q.pop_front();
        chk("result", 32'(got), 32'(want));
        $display("result value=%0h digits=%0d ovf=%0b err=%0b", got.v, got.d, got.o, got.e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    int         k;
    int         guard;
    logic [7:0] c;

    bus.in_valid  = 1'b0;
    bus.in_char   = 8'h00;
    bus.out_ready = 1'b1;

    #2;
    chk("rst_out_valid",  32'(bus.out_valid), 32'(0));
    chk("rst_out_value",  32'(bus.out_value), 32'(0));
    chk("rst_out_digits", 32'(bus.out_digits), 32'(0));
    chk("rst_out_ovf",    32'(bus.out_ovf), 32'(0));
    chk("rst_out_err",    32'(bus.out_err), 32'(0));
    chk("rst_busy",       32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'(1));

    // Table: expectations come from the table, not the model
    add("123 ",     16'h007B, 3'd3, 1'b0, 1'b0);
    add("1234567,", 16'h3039, 3'd5, 1'b0, 1'b1);
    add("0 ",       16'h0000, 3'd1, 1'b0, 1'b0);
    add("007;",     16'h0007, 3'd3, 1'b0, 1'b0);
`ifdef ASCII2BIN_SIGN_EN
    add("65536\n",  16'h7FFF, 3'd5, 1'b1, 1'b0);
    add("32767 ",   16'h7FFF, 3'd5, 1'b0, 1'b0);
    add("-32768 ",  16'h8000, 3'd5, 1'b0, 1'b0);
    add("-40000 ",  16'h8000, 3'd5, 1'b1, 1'b0);
    add("- ",       16'h0000, 3'd0, 1'b0, 1'b1);
    add("-5 ",      16'hFFFB, 3'd1, 1'b0, 1'b0);
    add("-12-",     16'hFFF4, 3'd2, 1'b0, 1'b0);
`else
    add("65536\n",  16'hFFFF, 3'd5, 1'b1, 1'b0);
    add("65535 ",   16'hFFFF, 3'd5, 1'b0, 1'b0);
    add("99999x",   16'hFFFF, 3'd5, 1'b1, 1'b0);
    add("-5 ",      16'h0005, 3'd1, 1'b0, 1'b0);
    add("\r,12\n",  16'h000C, 3'd2, 1'b0, 1'b0);
`endif
    use_model = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      exp_q.push_back(tbl[i].r);
      send_str(tbl[i].s);
      repeat (2) @(negedge clk);
    end
    use_model = 1'b1;

    // Terminator beat -> out_valid on the next cycle, for exactly one cycle when accepted
    send(8'h35);
    chk("accum_busy", 32'(busy), 32'(1));
    chk("pre_term_valid", 32'(bus.out_valid), 32'(0));
    send(8'h20);
    chk("latency_valid", 32'(bus.out_valid), 32'(1));
    chk("done_in_ready", 32'(bus.in_ready), 32'(0));
    @(negedge clk);
    chk("valid_drop", 32'(bus.out_valid), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));

    // Result held while the consumer stalls
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(negedge clk);
    send_str("  42;");
    repeat (3) begin
      chk("hold_valid", 32'(bus.out_valid), 32'(1));
      chk("hold_in_ready", 32'(bus.in_ready), 32'(0));
      chk("hold_value", 32'(bus.out_value), 32'(42));
      @(negedge clk);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    send_str("7 ");
    repeat (2) @(negedge clk);

    // Reset in the middle of a number
    send_str("12");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
    chk("mid_rst_value", 32'(bus.out_value), 32'(0));
    chk("mid_rst_digits", 32'(bus.out_digits), 32'(0));
    m_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_str("9 ");
    repeat (2) @(negedge clk);
    chk("queue_before_random", 32'(exp_q.size()), 32'(0));

    // Random stream with a randomly stalling consumer
    rand_rdy = 1'b1;
    fork
      begin
        while (rand_rdy) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 700; i++) begin
      k = $urandom_range(0, 15);
      if (k < 13) begin
        c = 8'h30 + 8'($urandom_range(0, 9));
      end else begin
        case ($urandom_range(0, 4))
          0:       c = 8'h20;
          1:       c = 8'h2C;
          2:       c = 8'h0A;
          3:       c = 8'h2D;
          default: c = 8'h00;
        endcase
      end
      if ($urandom_range(0, 7) == 0) @(negedge clk);
      send(c);
    end
    send(8'h20);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
